// File: rtl/fir_tdm_pkg.sv
// Shared constants, FSM state type and accumulator sizing for the TDM FIR MAC controller.
package fir_tdm_pkg;

    localparam int DATA_W = 16;
    localparam int COEF_W = 8;
    localparam int PROD_W = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_OUT  = 2'd2
    } fir_state_e;

    // Sum of num_taps full-width products needs clog2(num_taps) guard bits.
    function automatic int acc_w(input int num_taps);
        return PROD_W + $clog2(num_taps);
    endfunction

endpackage

// File: rtl/fir_tdm_coef_rf.sv
// Coefficient register file: NUM_TAPS x COEF_W, synchronous write, asynchronous read, reset to zero.
module fir_tdm_coef_rf
    import fir_tdm_pkg::*;
#(
    parameter int NUM_TAPS = 8,
    localparam int AW = $clog2(NUM_TAPS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_we,
    input  logic [AW-1:0]            i_waddr,
    input  logic signed [COEF_W-1:0] i_wdata,
    input  logic [AW-1:0]            i_raddr,
    output logic signed [COEF_W-1:0] o_rdata
);

    logic signed [COEF_W-1:0] r_coef [NUM_TAPS];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_coef[i] <= '0;
            end
        end else if (i_we && (int'(i_waddr) < NUM_TAPS)) begin
            r_coef[i_waddr] <= i_wdata;
        end
    end

    always_comb begin
        o_rdata = '0;
        if (int'(i_raddr) < NUM_TAPS) begin
            o_rdata = r_coef[i_raddr];
        end
    end

endmodule

// File: rtl/fir_tdm_mac_ctrl.sv
// Time-multiplexed FIR: one shared external multiplier, one tap per cycle, IDLE -> MAC -> OUT.
// Build option FIR_TDM_SAT_EN: saturate the shifted accumulator to OUT_W instead of wrapping.
module fir_tdm_mac_ctrl
    import fir_tdm_pkg::*;
#(
    parameter int NUM_TAPS = 8,
    parameter int SHIFT    = 7,
    parameter int OUT_W    = 16,
    localparam int AW      = $clog2(NUM_TAPS),
    localparam int ACC_W   = acc_w(NUM_TAPS)
) (
    input  logic                     ap_clk,
    input  logic                     ap_rst,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     coef_we,
    input  logic [AW-1:0]            coef_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic signed [DATA_W-1:0] mul_din0,
    output logic signed [COEF_W-1:0] mul_din1,
    input  logic signed [PROD_W-1:0] mul_dout,
    output logic                     busy
);

`ifdef FIR_TDM_SAT_EN
    localparam int CW = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
    localparam longint SAT_MAX_L = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam logic signed [CW-1:0] SAT_MAX = CW'(SAT_MAX_L);
    localparam logic signed [CW-1:0] SAT_MIN = CW'(-SAT_MAX_L - 1);
`endif

    fir_state_e r_state;
    fir_state_e w_next_state;

    logic [AW-1:0]            r_k;
    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_x [NUM_TAPS];
    logic signed [OUT_W-1:0]  r_out_data;

    logic                     w_accept;
    logic                     w_mac_last;
    logic signed [COEF_W-1:0] w_coef_rd;
    logic signed [ACC_W-1:0]  w_acc_next;

    function automatic logic signed [OUT_W-1:0] reduce_out(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> SHIFT;
`ifdef FIR_TDM_SAT_EN
        if (CW'(sh) > SAT_MAX) begin
            return OUT_W'(SAT_MAX);
        end else if (CW'(sh) < SAT_MIN) begin
            return OUT_W'(SAT_MIN);
        end
        return OUT_W'(sh);
`else
        return OUT_W'(sh);
`endif
    endfunction

    fir_tdm_coef_rf #(
        .NUM_TAPS (NUM_TAPS)
    ) u_coef_rf (
        .i_clk   (ap_clk),
        .i_rst   (ap_rst),
        .i_we    (coef_we),
        .i_waddr (coef_addr),
        .i_wdata (coef_wdata),
        .i_raddr (r_k),
        .o_rdata (w_coef_rd)
    );

    assign w_accept   = (r_state == ST_IDLE) && in_valid;
    assign w_mac_last = (r_state == ST_MAC) && (r_k == AW'(NUM_TAPS - 1));
    assign w_acc_next = r_acc + {{(ACC_W - PROD_W){mul_dout[PROD_W-1]}}, mul_dout};

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE: if (in_valid)   w_next_state = ST_MAC;
            ST_MAC:  if (w_mac_last) w_next_state = ST_OUT;
            ST_OUT:  if (out_ready)  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_OUT);
        busy      = (r_state != ST_IDLE);
        mul_din0  = '0;
        mul_din1  = '0;
        if (r_state == ST_MAC) begin
            mul_din0 = r_x[r_k];
            mul_din1 = w_coef_rd;
        end
    end

    // Datapath: delay line shifts only on accept; result is latched on the last tap.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_k        <= '0;
            r_acc      <= '0;
            r_out_data <= '0;
            for (int i = 0; i < NUM_TAPS; i++) begin
                r_x[i] <= '0;
            end
        end else if (w_accept) begin
            r_k   <= '0;
            r_acc <= '0;
            r_x[0] <= in_data;
            for (int i = 1; i < NUM_TAPS; i++) begin
                r_x[i] <= r_x[i-1];
            end
        end else if (r_state == ST_MAC) begin
            r_acc <= w_acc_next;
            if (w_mac_last) begin
                r_k        <= '0;
                r_out_data <= reduce_out(w_acc_next);
            end else begin
                r_k <= r_k + AW'(1);
            end
        end
    end

    assign out_data = r_out_data;

endmodule

// File: tb/tb_fir_tdm_mac_ctrl.sv
// Directed + randomized bench for fir_tdm_mac_ctrl with an array-based FIR reference model.
module tb_fir_tdm_mac_ctrl;

    localparam int N     = 8;
    localparam int SHIFT = 7;
    localparam int OUT_W = 16;
    localparam int AW    = $clog2(N);

    logic                     ap_clk = 1'b0;
    logic                     ap_rst = 1'b1;
    logic signed [15:0]       in_data = '0;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic                     coef_we = 1'b0;
    logic [AW-1:0]            coef_addr = '0;
    logic signed [7:0]        coef_wdata = '0;
    logic signed [15:0]       mul_din0;
    logic signed [7:0]        mul_din1;
    logic signed [23:0]       mul_dout;
    logic                     busy;

    int n_cmp = 0;
    int n_err = 0;

    longint mcoef [N];
    longint hist  [N];

    always #5 ap_clk = ~ap_clk;

    assign mul_dout = 24'(mul_din0) * 24'(mul_din1);

    fir_tdm_mac_ctrl #(.NUM_TAPS(N), .SHIFT(SHIFT), .OUT_W(OUT_W)) dut (
        .ap_clk     (ap_clk),
        .ap_rst     (ap_rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .coef_we    (coef_we),
        .coef_addr  (coef_addr),
        .coef_wdata (coef_wdata),
        .mul_din0   (mul_din0),
        .mul_din1   (mul_din1),
        .mul_dout   (mul_dout),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // y = sum coef[k]*x[n-k], arithmetic shift, then saturate or keep low OUT_W bits
    function automatic longint model_out();
        longint acc = 0;
        longint sh;
        longint lim = (longint'(1) <<< (OUT_W - 1));
        logic signed [OUT_W-1:0] t;
        for (int k = 0; k < N; k++) acc += hist[k] * mcoef[k];
        sh = acc >>> SHIFT;
`ifdef FIR_TDM_SAT_EN
        if (sh > lim - 1) return lim - 1;
        if (sh < -lim) return -lim;
        return sh;
`else
        t = OUT_W'(sh);
        return longint'(t);
`endif
    endfunction

    function automatic void model_push(input longint d);
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = d;
    endfunction

    task automatic wr_coef(input int a, input longint d);
        coef_we = 1'b1; coef_addr = AW'(a); coef_wdata = 8'(d);
        @(negedge ap_clk);
        coef_we = 1'b0;
        mcoef[a] = d;
    endtask

    // wr_cyc: -1 none, 0 same cycle as accept, k+1 while MAC is on tap k
    task automatic run(input string tag, input logic signed [15:0] d, input longint expv,
                       input int wr_cyc, input int waddr, input logic signed [7:0] wdata);
        int lat;
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        in_data = d; in_valid = 1'b1;
        if (wr_cyc == 0) begin
            coef_we = 1'b1; coef_addr = AW'(waddr); coef_wdata = wdata;
        end
        @(negedge ap_clk);
        in_valid = 1'b0; in_data = 16'($urandom); coef_we = 1'b0;
        lat = 0;
        while (!out_valid && lat < 4 * N) begin
            chk({tag, ".in_ready_busy"}, {in_ready, busy}, 2'b01);
            if (wr_cyc > 0 && lat == wr_cyc - 1) begin
                coef_we = 1'b1; coef_addr = AW'(waddr); coef_wdata = wdata;
            end else begin
                coef_we = 1'b0;
            end
            @(negedge ap_clk);
            lat++;
        end
        coef_we = 1'b0;
        chk({tag, ".latency"}, lat, N);
        chk({tag, ".out_data"}, out_data, expv);
        if (out_ready) begin
            @(negedge ap_clk);
            chk({tag, ".back_to_idle"}, {out_valid, in_ready}, 2'b01);
        end
    endtask

    task automatic send(input string tag, input logic signed [15:0] d);
        model_push(longint'(d));
        run(tag, d, model_out(), -1, 0, 8'sd0);
    endtask

    task automatic model_clear();
        for (int k = 0; k < N; k++) begin mcoef[k] = 0; hist[k] = 0; end
    endtask

    initial begin
        longint e;
        logic signed [15:0] d;
        model_clear();

        // reset state
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("rst.in_ready", in_ready, 1);
        chk("rst.busy", busy, 0);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_data", out_data, 0);
        chk("rst.mul_din", {mul_din0, mul_din1}, 0);

        // impulse: x=128 with SHIFT=7 is unit gain, so outputs replay coefficients 1..8
        for (int k = 0; k < N; k++) wr_coef(k, k + 1);
        for (int i = 0; i < N; i++) begin
            d = (i == 0) ? 16'sd128 : 16'sd0;
            model_push(longint'(d));
            run("impulse", d, longint'(i + 1), -1, 0, 8'sd0);
        end

        // random coefficients and samples
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) wr_coef(k, longint'($signed(8'($urandom))));
            for (int i = 0; i < 10; i++) send("random", 16'($urandom));
        end

        // saturation / wrap with full-scale input and coefficients
        for (int k = 0; k < N; k++) wr_coef(k, 127);
        for (int i = 0; i < N; i++) begin
            model_push(32767);
            e = model_out();
            if (i == N - 1) begin
`ifdef FIR_TDM_SAT_EN
                chk("sat.model_const", e, 32767);
                e = 32767;
`else
                chk("wrap.model_const", e, -2056);
                e = -2056;
`endif
            end
            run("fullscale", 16'sd32767, e, -1, 0, 8'sd0);
        end

        // backpressure: output held, in_valid ignored, no shift
        for (int k = 0; k < N; k++) wr_coef(k, longint'($signed(8'($urandom))));
        out_ready = 1'b0;
        d = 16'($urandom);
        model_push(longint'(d));
        e = model_out();
        run("bp", d, e, -1, 0, 8'sd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_data = 16'($urandom);
            @(negedge ap_clk);
            chk("bp.hold_data", out_data, e);
            chk("bp.valid_ready", {out_valid, in_ready}, 2'b10);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp.release", {out_valid, in_ready}, 2'b01);
        send("bp.no_shift", 16'($urandom));

        // coefficient write while MAC sits on tap 4
        d = 16'($urandom);
        model_push(longint'(d));
        mcoef[6] = 10;
        run("wr_ahead", d, model_out(), 5, 6, 8'sd10);
        d = 16'($urandom);
        model_push(longint'(d));
        e = model_out();
        mcoef[1] = 10;
        run("wr_behind", d, e, 5, 1, 8'sd10);
        send("wr_behind.next", 16'($urandom));

        // write in the accept cycle is used by this sample
        d = 16'($urandom);
        model_push(longint'(d));
        mcoef[0] = -77;
        run("wr_same", d, model_out(), 0, 0, -8'sd77);

        // reset while MAC is on tap 3
        in_data = 16'sd1000; in_valid = 1'b1;
        @(negedge ap_clk);
        in_valid = 1'b0;
        repeat (3) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        ap_rst = 1'b0;
        chk("midrst.state", {out_valid, busy, in_ready}, 3'b001);
        chk("midrst.out_data", out_data, 0);
        repeat (N + 3) @(negedge ap_clk);
        chk("midrst.no_output", out_valid, 0);
        model_clear();
        for (int k = 0; k < N; k++) wr_coef(k, k + 1);
        for (int i = 0; i < N; i++) begin
            d = (i == 0) ? 16'sd128 : 16'sd0;
            model_push(longint'(d));
            run("impulse2", d, longint'(i + 1), -1, 0, 8'sd0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
